// File: rtl/obstacle_scheduler_if.sv
// Mode/tick inputs and packed per-slot obstacle coordinate buses of obstacle_scheduler.
interface obstacle_scheduler_if #(
  parameter int unsigned N_OBS = 10
) ();
  logic                  frame_tick;
  logic [1:0]            gamemode;
  logic [N_OBS-1:0][9:0] obstacle_x_game_left;
  logic [N_OBS-1:0][9:0] obstacle_x_game_right;
  logic [N_OBS-1:0][8:0] obstacle_y_game_up;
  logic [N_OBS-1:0][8:0] obstacle_y_game_down;
  logic [N_OBS-1:0]      obstacle_active;
  logic [15:0]           score;

  modport master (
    output frame_tick, gamemode,
    input  obstacle_x_game_left, obstacle_x_game_right,
    input  obstacle_y_game_up, obstacle_y_game_down,
    input  obstacle_active, score
  );

  modport slave (
    input  frame_tick, gamemode,
    output obstacle_x_game_left, obstacle_x_game_right,
    output obstacle_y_game_up, obstacle_y_game_down,
    output obstacle_active, score
  );
endinterface

// File: rtl/obstacle_scheduler.sv
// Obstacle slot table: spawns at the right edge, scrolls left per frame tick,
// retires off the left edge and counts retirements as score; sequenced by gamemode.
module obstacle_scheduler #(
  parameter int unsigned N_OBS     = 10,
  parameter int unsigned SCREEN_W  = 640,
  parameter int unsigned OBS_W     = 40,
  parameter int unsigned OBS_H     = 120,
  parameter int unsigned SPEED     = 2,
  parameter int unsigned SPAWN_GAP = 160,
  parameter int unsigned Y_BASE    = 40,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 rst,
  obstacle_scheduler_if.slave  bus
);
  localparam int unsigned   CW        = $clog2(SPAWN_GAP + SPEED) + 1;
  localparam logic [1:0]    MODE_MENU = 2'b00;
  localparam logic [1:0]    MODE_PLAY = 2'b01;
  localparam logic [15:0]   LFSR_TAPS = 16'hB400;
  localparam logic [9:0]    X_SPAWN_L = 10'(SCREEN_W);
  localparam logic [9:0]    X_SPAWN_R = 10'(SCREEN_W + OBS_W);
  localparam logic [9:0]    X_STEP    = 10'(SPEED);
  localparam logic [8:0]    Y_OFF     = 9'(Y_BASE);
  localparam logic [8:0]    Y_SPAN    = 9'(OBS_H);
  localparam logic [CW-1:0] DIST_GAP  = CW'(SPAWN_GAP);
  localparam logic [CW-1:0] DIST_STEP = CW'(SPEED);

  logic [N_OBS-1:0][9:0] r_left, r_right, w_left_nx, w_right_nx;
  logic [N_OBS-1:0][8:0] r_up, r_down, w_up_nx, w_down_nx;
  logic [N_OBS-1:0]      r_active, w_active_nx;
  logic [15:0]           r_score, w_score_nx, w_retire_cnt;
  logic [CW-1:0]         r_dist, w_dist_nx, w_dist_add, w_dist_sat;
  logic [15:0]           r_lfsr, w_lfsr_nx, w_lfsr_step;
  logic [N_OBS-1:0]      w_free, w_spawn_oh;
  logic                  w_spawn;
  logic [8:0]            w_spawn_up, w_spawn_down;

  // Lowest free slot isolated as a one-hot mask from the start-of-tick state.
  assign w_free       = ~r_active;
  assign w_spawn_oh   = w_free & (~w_free + N_OBS'(1));
  assign w_dist_add   = r_dist + DIST_STEP;
  assign w_dist_sat   = (w_dist_add >= DIST_GAP) ? DIST_GAP : w_dist_add;
  assign w_spawn      = (w_dist_sat >= DIST_GAP) && (|w_free);
  assign w_lfsr_step  = r_lfsr[0] ? ((r_lfsr >> 1) ^ LFSR_TAPS) : (r_lfsr >> 1);
  assign w_spawn_up   = Y_OFF + 9'(r_lfsr[7:0]);
  assign w_spawn_down = w_spawn_up + Y_SPAN;

  always_comb begin
    w_left_nx    = r_left;
    w_right_nx   = r_right;
    w_up_nx      = r_up;
    w_down_nx    = r_down;
    w_active_nx  = r_active;
    w_score_nx   = r_score;
    w_dist_nx    = r_dist;
    w_lfsr_nx    = r_lfsr;
    w_retire_cnt = '0;
    case (bus.gamemode)
      MODE_MENU: begin
        w_left_nx   = '0;
        w_right_nx  = '0;
        w_up_nx     = '0;
        w_down_nx   = '0;
        w_active_nx = '0;
        w_score_nx  = '0;
        w_dist_nx   = DIST_GAP;
      end
      MODE_PLAY: begin
        if (bus.frame_tick) begin
          for (int i = 0; i < int'(N_OBS); i++) begin
            if (r_active[i]) begin
              if (r_left[i] < X_STEP) begin
                w_left_nx[i]   = '0;
                w_right_nx[i]  = '0;
                w_up_nx[i]     = '0;
                w_down_nx[i]   = '0;
                w_active_nx[i] = 1'b0;
                w_retire_cnt   = w_retire_cnt + 16'd1;
              end else begin
                w_left_nx[i]  = r_left[i] - X_STEP;
                w_right_nx[i] = r_right[i] - X_STEP;
              end
            end
          end
          w_score_nx = r_score + w_retire_cnt;
          w_dist_nx  = w_dist_sat;
          // A deferred spawn leaves the counter saturated at the gap.
          if (w_spawn) begin
            for (int i = 0; i < int'(N_OBS); i++) begin
              if (w_spawn_oh[i]) begin
                w_left_nx[i]   = X_SPAWN_L;
                w_right_nx[i]  = X_SPAWN_R;
                w_up_nx[i]     = w_spawn_up;
                w_down_nx[i]   = w_spawn_down;
                w_active_nx[i] = 1'b1;
              end
            end
            w_dist_nx = '0;
            w_lfsr_nx = w_lfsr_step;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_left   <= '0;
      r_right  <= '0;
      r_up     <= '0;
      r_down   <= '0;
      r_active <= '0;
      r_score  <= '0;
      r_dist   <= '0;
      r_lfsr   <= LFSR_SEED;
    end else begin
      r_left   <= w_left_nx;
      r_right  <= w_right_nx;
      r_up     <= w_up_nx;
      r_down   <= w_down_nx;
      r_active <= w_active_nx;
      r_score  <= w_score_nx;
      r_dist   <= w_dist_nx;
      r_lfsr   <= w_lfsr_nx;
    end
  end

  assign bus.obstacle_x_game_left  = r_left;
  assign bus.obstacle_x_game_right = r_right;
  assign bus.obstacle_y_game_up    = r_up;
  assign bus.obstacle_y_game_down  = r_down;
  assign bus.obstacle_active       = r_active;
  assign bus.score                 = r_score;
endmodule
